// File: rtl/key_debounce_array.sv
// key_debounce_array: N-key 2-FF synchroniser, shared tick prescaler, debounce, press/release/long strobes.
// Define KEYDB_AUTOREPEAT_EN to make LONG repeat every REPEAT_TICKS ticks while a key stays held.
module key_debounce_array #(
    parameter int N_KEYS         = 4,
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 16,
    parameter int LONG_TICKS     = 1000,
    parameter int REPEAT_TICKS   = 200,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] PRESSED,
    output logic [N_KEYS-1:0] PUSHED,
    output logic [N_KEYS-1:0] RELEASED,
    output logic [N_KEYS-1:0] LONG,
    output logic              TICK
);

    localparam int PW = $clog2(TICK_DIV) + 1;
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(LONG_TICKS);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(LONG_TICKS - 1);

    if (N_KEYS < 1 || TICK_DIV < 1 || DEBOUNCE_TICKS < 1 ||
        LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : gBadParams
        $error("key_debounce_array: parameter out of range");
    end

    logic [PW-1:0]     prescCount;
    logic [N_KEYS-1:0] syncA;
    logic [N_KEYS-1:0] syncB;

    always_ff @(posedge CLK) begin
        if (RST) begin
            prescCount <= '0;
        end else if (prescCount == PRESC_LAST) begin
            prescCount <= '0;
        end else begin
            prescCount <= prescCount + 1'b1;
        end
    end

    assign TICK = (prescCount == PRESC_LAST);

    // Normalised so that 1 = pressed regardless of pin polarity.
    always_ff @(posedge CLK) begin
        if (RST) begin
            syncA <= '0;
            syncB <= '0;
        end else begin
            syncA <= KEY ^ {N_KEYS{KEY_ACTIVE_LOW}};
            syncB <= syncA;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : gKey
        logic [DW-1:0] dbCount;
        logic [HW-1:0] holdCount;
        logic          pressedQ;
        logic          pushedQ;
        logic          releasedQ;
        logic          longQ;
        logic          differ;
        logic          flip;

        assign differ = (syncB[i] != pressedQ);
        assign flip   = TICK && differ && (dbCount == DB_LAST);

        always_ff @(posedge CLK) begin
            if (RST) begin
                dbCount   <= '0;
                pressedQ  <= 1'b0;
                pushedQ   <= 1'b0;
                releasedQ <= 1'b0;
            end else begin
                pushedQ   <= 1'b0;
                releasedQ <= 1'b0;
                if (TICK) begin
                    if (!differ) begin
                        dbCount <= '0;
                    end else if (flip) begin
                        dbCount   <= '0;
                        pressedQ  <= ~pressedQ;
                        pushedQ   <= ~pressedQ;
                        releasedQ <= pressedQ;
                    end else begin
                        dbCount <= dbCount + 1'b1;
                    end
                end
            end
        end

`ifdef KEYDB_AUTOREPEAT_EN
        localparam int RW = $clog2(REPEAT_TICKS + 1);
        localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);

        logic [RW-1:0] repCount;

        always_ff @(posedge CLK) begin
            if (RST) begin
                holdCount <= '0;
                repCount  <= '0;
                longQ     <= 1'b0;
            end else begin
                longQ <= 1'b0;
                if (TICK) begin
                    // A debounce flip on this tick wins over any hold event.
                    if (flip || !pressedQ) begin
                        holdCount <= '0;
                        repCount  <= '0;
                    end else if (holdCount != HOLD_MAX) begin
                        holdCount <= holdCount + 1'b1;
                        longQ     <= (holdCount == HOLD_LAST);
                    end else if (repCount == REP_LAST) begin
                        repCount <= '0;
                        longQ    <= 1'b1;
                    end else begin
                        repCount <= repCount + 1'b1;
                    end
                end
            end
        end
`else
        always_ff @(posedge CLK) begin
            if (RST) begin
                holdCount <= '0;
                longQ     <= 1'b0;
            end else begin
                longQ <= 1'b0;
                if (TICK) begin
                    // A debounce flip on this tick wins over any hold event.
                    if (flip || !pressedQ) begin
                        holdCount <= '0;
                    end else if (holdCount != HOLD_MAX) begin
                        holdCount <= holdCount + 1'b1;
                        longQ     <= (holdCount == HOLD_LAST);
                    end
                end
            end
        end
`endif

        assign PRESSED[i]  = pressedQ;
        assign PUSHED[i]   = pushedQ;
        assign RELEASED[i] = releasedQ;
        assign LONG[i]     = longQ;
    end

endmodule
